uart_stream_collector: RTL and testbench
========================================

// Module: uart_stream_collector
// PURPOSE
//  UART receiver with a small elastic buffer. Takes an 8N1 serial line
//  and presents received bytes as an AXI-Stream-style byte stream
//  (tdata/tlast/tvalid/tready). It is the inbound counterpart of the
//  emitter, and sits between the board RX pin and a byte consumer in the
//  corescore top levels.
// PARAMETERS
//  CLK_FREQ_HZ  16000000  i_clk frequency in Hz
//  BAUD_RATE    57600     line rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (integer division, must be >= 4)
//  FIFO_AW      4         FIFO address width; depth = 2**FIFO_AW entries
//  LAST_CHAR    8'h0A     byte value that is flagged with tlast
// PORTS
//  i_clk      in   1  clock
//  i_rst      in   1  synchronous, active-high reset
//  i_uart_rx  in   1  asynchronous serial input, idle high
//  o_tdata    out  8  head-of-FIFO byte
//  o_tlast    out  1  high when o_tdata == LAST_CHAR (stored per entry)
//  o_tvalid   out  1  FIFO not empty
//  i_tready   in   1  consumer accepts o_tdata when o_tvalid && i_tready
//  o_frame_err out 1  one-cycle pulse: stop bit sampled low
//  o_overrun  out  1  one-cycle pulse: byte completed while FIFO full, byte dropped
// BEHAVIOUR
//  Reset: o_tvalid=0, o_tdata=0, o_tlast=0, o_frame_err=0, o_overrun=0.
//   FIFO is emptied and the FSM goes to IDLE. The synchronizer flops are
//   set to 1. Reset mid-frame discards the partial byte.
//  Input: 2-flop synchronizer on i_uart_rx. All decisions use the synced value.
//  Baud counter counts 0..CLKS_PER_BIT-1. The bit index counts 0..7. LSB is first.
//  FSM states:
//   IDLE  : a synced 1->0 edge loads the counter with CLKS_PER_BIT/2 and moves to START.
//   START : at expiry, sample the line. If it is 1, treat as a glitch and go to IDLE.
//           If it is 0, go to DATA with a full-bit reload.
//   DATA  : sample at each expiry into shift[7] and shift right.
//           After 8 samples, go to STOP.
//   STOP  : sample at expiry.
//           - 1: push the byte, then go to IDLE.
//           - 0: pulse o_frame_err, drop the byte, then go to BREAK.
//   BREAK : stay until the synced line is 1, then go to IDLE.
//           This prevents a held-low line from producing 0x00 bytes.
//  Push happens in the cycle of the stop-bit sample. The byte is visible on
//   o_tvalid/o_tdata the next cycle, so latency from the stop-bit sample
//   point to o_tvalid is 1 cycle.
//  FIFO: first-word-fall-through. o_tdata/o_tlast come from the head entry.
//   o_tdata holds stable while o_tvalid && !i_tready.
//  Pop occurs when o_tvalid && i_tready.
//  Simultaneous push and pop when the FIFO is full: push is accepted and
//   the count is unchanged. No o_overrun.
//  Push while full with no pop: the byte is dropped, o_overrun pulses,
//   and the FIFO contents are untouched.
//  Simultaneous push and pop when the FIFO is empty: the pop cannot occur
//   (o_tvalid=0). The byte appears the next cycle.
//  The occupancy counter is FIFO_AW+1 bits wide. Pointers are FIFO_AW bits
//   and wrap naturally.
//  A frame error and an overrun are mutually exclusive per frame.
//  The consumer may stall indefinitely; reception continues until overrun.
// TESTING (bench: CLK_FREQ_HZ=16000000, BAUD_RATE=1000000 -> 16 clk/bit, FIFO_AW=2)
//  1. Send 0x55, tready=1 -> o_tdata=0x55, tvalid for 1 cycle, tlast=0, no error pulses.
//  2. Send 0x48,0x69,0x0A, tready=0, then raise tready -> 3 beats 48,69,0A in order;
//     tlast=1 only on 0x0A.
//  3. Send 5 bytes 0x01..0x05 with tready=0 -> 4 stored; o_overrun pulses once on 0x05;
//     drain yields 01..04.
//  4. Send a 0xA5 frame with stop bit=0, then line high -> o_frame_err pulses once,
//     nothing pushed; next 0x3C received OK.
//  5. 4-clk low glitch on idle line -> no byte, no errors.
//     Line held low 40 bit-times -> exactly one o_frame_err, no bytes.
//  6. Assert i_rst during DATA of a byte and also with 2 bytes queued ->
//     tvalid=0 the next cycle, partial byte discarded; following 0x7E received correctly.

Source files
------------

// File: rtl/uart_stream_collector.sv
// ---------------------------------------------------------------------------
// uart_stream_collector
//
// 8N1 UART receiver feeding a small first-word-fall-through FIFO. Received
// bytes are presented as a byte stream (tdata/tlast/tvalid/tready).
//
// Parameters
//   CLK_FREQ_HZ : i_clk frequency in Hz
//   BAUD_RATE   : serial line rate. CLK_FREQ_HZ/BAUD_RATE must be >= 4.
//   FIFO_AW     : FIFO address width, depth = 2**FIFO_AW entries
//   LAST_CHAR   : byte value that is flagged with tlast
//
// Ports
//   i_clk       : clock
//   i_rst       : synchronous active-high reset
//   i_uart_rx   : asynchronous serial input, idle high
//   o_tdata     : byte at the head of the FIFO, 0 when the FIFO is empty
//   o_tlast     : head byte equals LAST_CHAR
//   o_tvalid    : FIFO not empty
//   i_tready    : consumer takes the head byte when o_tvalid && i_tready
//   o_frame_err : one-cycle pulse, stop bit sampled low
//   o_overrun   : one-cycle pulse, byte completed while FIFO full and dropped
// ---------------------------------------------------------------------------
module uart_stream_collector #(
    parameter int         CLK_FREQ_HZ = 16000000,
    parameter int         BAUD_RATE   = 57600,
    parameter int         FIFO_AW     = 4,
    parameter logic [7:0] LAST_CHAR   = 8'h0A
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uart_rx,
    output logic [7:0] o_tdata,
    output logic       o_tlast,
    output logic       o_tvalid,
    input  logic       i_tready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int DEPTH        = 2 ** FIFO_AW;

    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // Synchronizer and edge detect
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;

    // Receiver state and datapath
    rx_state_t        state, state_next;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_next;
    logic [2:0]       bit_idx, bit_idx_next;
    logic [7:0]       shift, shift_next;
    logic             push_req;
    logic             frame_err_next;
    logic             baud_expire;

    // FIFO
    logic [8:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               fifo_full;
    logic               pop;
    logic               wr_en;
    logic               overrun_next;
    logic [8:0]         head;

    // Two-flop synchronizer plus one extra stage so the falling edge can be
    // detected on the synced value. All stages reset to the idle-high level
    // so leaving reset never looks like a start bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign baud_expire = (baud_cnt == CNT_MAX);

    // Receiver state register together with the bit-timing datapath.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_idx  <= bit_idx_next;
            shift    <= shift_next;
        end
    end

    // Next-state logic. The baud counter free-runs 0..CLKS_PER_BIT-1 while a
    // frame is in progress. Loading half a bit on the start edge places every
    // later sample in the middle of its bit.
    always_comb begin
        state_next     = state;
        baud_cnt_next  = baud_expire ? '0 : baud_cnt + CNT_W'(1);
        bit_idx_next   = bit_idx;
        shift_next     = shift;
        push_req       = 1'b0;
        frame_err_next = 1'b0;

        case (state)
            IDLE: begin
                baud_cnt_next = baud_cnt;
                if (rx_prev && !rx_sync) begin
                    baud_cnt_next = CNT_HALF;
                    state_next    = START;
                end
            end
            START: begin
                if (baud_expire) begin
                    if (rx_sync) begin
                        // Line went back high before mid start bit: glitch.
                        state_next = IDLE;
                    end else begin
                        state_next   = DATA;
                        bit_idx_next = '0;
                    end
                end
            end
            DATA: begin
                if (baud_expire) begin
                    shift_next = {rx_sync, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (baud_expire) begin
                    if (rx_sync) begin
                        push_req   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = BREAK;
                    end
                end
            end
            BREAK: begin
                // Wait out a held-low line so it cannot be read as 0x00 bytes.
                baud_cnt_next = baud_cnt;
                if (rx_sync) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A push while full is only accepted when the head is being popped in
    // the same cycle; then the freed slot is exactly the one written.
    assign fifo_full    = (count == FULL_CNT);
    assign pop          = o_tvalid && i_tready;
    assign wr_en        = push_req && (!fifo_full || pop);
    assign overrun_next = push_req && fifo_full && !pop;

    // FIFO pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + (FIFO_AW + 1)'(1);
                2'b01:   count <= count - (FIFO_AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage holds {tlast, tdata}; tlast is decided once, at push time.
    always_ff @(posedge i_clk) begin
        if (!i_rst && wr_en) begin
            mem[wr_ptr] <= {(shift == LAST_CHAR), shift};
        end
    end

    // Status pulses line up with the cycle in which a pushed byte would
    // first become visible.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_frame_err <= frame_err_next;
            o_overrun   <= overrun_next;
        end
    end

    // Head entry is masked while empty so the stream outputs read zero
    // after reset instead of stale memory contents.
    assign head     = mem[rd_ptr];
    assign o_tvalid = (count != '0);
    assign o_tdata  = o_tvalid ? head[7:0] : 8'h00;
    assign o_tlast  = o_tvalid ? head[8] : 1'b0;

endmodule

// File: tb/tb_uart_stream_collector.sv
// ---------------------------------------------------------------------------
// tb_uart_stream_collector
//
// Directed bench for uart_stream_collector at 16 clocks per bit with a
// 4-entry FIFO. A monitor logs every accepted beat and counts status
// pulses; each test compares the deltas against hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_stream_collector;

    localparam int CLKS_PER_BIT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       tready;
    logic [7:0] tdata;
    logic       tlast;
    logic       tvalid;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    logic [8:0] beat_log [$];
    int         ferr_cnt  = 0;
    int         ovr_cnt   = 0;
    int         valid_cyc = 0;

    int b0;
    int f0;
    int o0;
    int v0;

    uart_stream_collector #(
        .CLK_FREQ_HZ(16000000),
        .BAUD_RATE  (1000000),
        .FIFO_AW    (2),
        .LAST_CHAR  (8'h0A)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_uart_rx  (rx),
        .o_tdata    (tdata),
        .o_tlast    (tlast),
        .o_tvalid   (tvalid),
        .i_tready   (tready),
        .o_frame_err(frame_err),
        .o_overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (tvalid && tready) beat_log.push_back({tlast, tdata});
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (overrun) ovr_cnt = ovr_cnt + 1;
        if (tvalid) valid_cyc = valid_cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 8N1 frame, LSB first; stop_bit=0 forces a framing error.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            waitCycles(CLKS_PER_BIT);
        end
        rx = 1'b1;
    endtask

    task automatic checkBeat(input string tag, input int idx, input logic [7:0] d, input logic l);
        logic [31:0] got;
        if (idx < beat_log.size()) got = 32'(beat_log[idx]);
        else got = 32'hDEAD;
        checkOutput(tag, got, {23'd0, l, d});
    endtask

    task automatic snapshot();
        b0 = beat_log.size();
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        v0 = valid_cyc;
    endtask

    initial begin
        rst    = 1'b1;
        rx     = 1'b1;
        tready = 1'b0;
        waitCycles(4);

        // Reset state
        checkOutput("rst_tvalid", 32'(tvalid), 32'd0);
        checkOutput("rst_tdata", 32'(tdata), 32'd0);
        checkOutput("rst_tlast", 32'(tlast), 32'd0);
        checkOutput("rst_ferr", 32'(frame_err), 32'd0);
        checkOutput("rst_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        waitCycles(10);

        // Test 1: single byte, consumer ready
        tready = 1'b1;
        snapshot();
        applyStimulus(8'h55, 1'b1);
        waitCycles(20);
        checkOutput("t1_beats", 32'(beat_log.size() - b0), 32'd1);
        checkBeat("t1_beat0", b0, 8'h55, 1'b0);
        checkOutput("t1_valid_cyc", 32'(valid_cyc - v0), 32'd1);
        checkOutput("t1_ferr", 32'(ferr_cnt - f0), 32'd0);
        checkOutput("t1_ovr", 32'(ovr_cnt - o0), 32'd0);

        // Test 2: three bytes queued behind a stalled consumer
        tready = 1'b0;
        snapshot();
        applyStimulus(8'h48, 1'b1);
        applyStimulus(8'h69, 1'b1);
        applyStimulus(8'h0A, 1'b1);
        waitCycles(20);
        checkOutput("t2_stall_tvalid", 32'(tvalid), 32'd1);
        checkOutput("t2_stall_tdata", 32'(tdata), 32'h48);
        checkOutput("t2_stall_tlast", 32'(tlast), 32'd0);
        waitCycles(7);
        checkOutput("t2_hold_tdata", 32'(tdata), 32'h48);
        tready = 1'b1;
        waitCycles(10);
        checkOutput("t2_beats", 32'(beat_log.size() - b0), 32'd3);
        checkBeat("t2_beat0", b0, 8'h48, 1'b0);
        checkBeat("t2_beat1", b0 + 1, 8'h69, 1'b0);
        checkBeat("t2_beat2", b0 + 2, 8'h0A, 1'b1);
        checkOutput("t2_drained", 32'(tvalid), 32'd0);

        // Test 3: overrun on the fifth byte into a 4-entry FIFO
        tready = 1'b0;
        snapshot();
        for (int i = 1; i <= 4; i++) applyStimulus(8'(i), 1'b1);
        waitCycles(20);
        checkOutput("t3_ovr_before", 32'(ovr_cnt - o0), 32'd0);
        applyStimulus(8'h05, 1'b1);
        waitCycles(20);
        checkOutput("t3_ovr_after", 32'(ovr_cnt - o0), 32'd1);
        checkOutput("t3_ferr", 32'(ferr_cnt - f0), 32'd0);
        tready = 1'b1;
        waitCycles(10);
        checkOutput("t3_beats", 32'(beat_log.size() - b0), 32'd4);
        for (int i = 0; i < 4; i++) checkBeat("t3_beat", b0 + i, 8'(i + 1), 1'b0);

        // Test 4: framing error, then a good byte
        snapshot();
        applyStimulus(8'hA5, 1'b0);
        waitCycles(20);
        checkOutput("t4_ferr", 32'(ferr_cnt - f0), 32'd1);
        checkOutput("t4_no_beat", 32'(beat_log.size() - b0), 32'd0);
        applyStimulus(8'h3C, 1'b1);
        waitCycles(20);
        checkOutput("t4_beats", 32'(beat_log.size() - b0), 32'd1);
        checkBeat("t4_beat0", b0, 8'h3C, 1'b0);
        checkOutput("t4_ferr_total", 32'(ferr_cnt - f0), 32'd1);

        // Test 5: short glitch, then a long break
        snapshot();
        rx = 1'b0;
        waitCycles(4);
        rx = 1'b1;
        waitCycles(40);
        checkOutput("t5_glitch_beats", 32'(beat_log.size() - b0), 32'd0);
        checkOutput("t5_glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
        rx = 1'b0;
        waitCycles(40 * CLKS_PER_BIT);
        rx = 1'b1;
        waitCycles(40);
        checkOutput("t5_break_ferr", 32'(ferr_cnt - f0), 32'd1);
        checkOutput("t5_break_beats", 32'(beat_log.size() - b0), 32'd0);
        checkOutput("t5_break_ovr", 32'(ovr_cnt - o0), 32'd0);

        // Test 6: reset with two bytes queued and a frame in progress
        tready = 1'b0;
        snapshot();
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        waitCycles(5);
        checkOutput("t6_queued", 32'(tvalid), 32'd1);
        rx = 1'b0;
        waitCycles(CLKS_PER_BIT);
        rx = 1'b1;
        waitCycles(CLKS_PER_BIT);
        rx = 1'b0;
        waitCycles(CLKS_PER_BIT / 2);
        rst = 1'b1;
        rx  = 1'b1;
        waitCycles(1);
        checkOutput("t6_rst_tvalid", 32'(tvalid), 32'd0);
        rst = 1'b0;
        waitCycles(40);
        checkOutput("t6_post_tvalid", 32'(tvalid), 32'd0);
        checkOutput("t6_post_ferr", 32'(ferr_cnt - f0), 32'd0);
        tready = 1'b1;
        snapshot();
        applyStimulus(8'h7E, 1'b1);
        waitCycles(20);
        checkOutput("t6_beats", 32'(beat_log.size() - b0), 32'd1);
        checkBeat("t6_beat0", b0, 8'h7E, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
